wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 89 ++++++++
 tb/tb_wb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter. It chooses between an ALU port and an LSU port,
// with LSU starvation relief, and keeps a pending-load scoreboard that stalls decode.
module wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [4:0]            lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  input  logic                  issue_valid,
  input  logic                  issue_long,
  input  logic [4:0]            issue_rd,
  input  logic [4:0]            issue_rs1,
  input  logic [4:0]            issue_rs2,
  output logic                  stall,
  output logic                  RegWrite,
  output logic [4:0]            write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  wb_err
);

  localparam logic [1:0] SMAX = 2'(STARVE_MAX);

  logic [1:0]            starve_cnt;
  logic [31:0]           pending;
  logic [31:0]           set_vec, clr_vec;
  logic                  force_lsu, alu_gnt, lsu_gnt, hit;
  logic                  gnt, gnt_we;
  logic [4:0]            gnt_rd;
  logic [DATA_WIDTH-1:0] gnt_data;

  always_comb begin
    force_lsu = lsu_valid && (starve_cnt == SMAX);
    // Grants and stall are gated by rst so that they read 0 while reset is held.
    alu_gnt   = rst && alu_valid && !force_lsu;
    lsu_gnt   = rst && lsu_valid && !alu_gnt;
    hit       = pending[issue_rs1] | pending[issue_rs2] | pending[issue_rd];
    stall     = rst && issue_valid && hit;

    gnt      = alu_gnt || lsu_gnt;
    gnt_rd   = alu_gnt ? alu_rd   : lsu_rd;
    gnt_data = alu_gnt ? alu_data : lsu_data;
    gnt_we   = gnt && (gnt_rd != 5'd0);

    set_vec = '0;
    if (issue_valid && issue_long && (issue_rd != 5'd0) && !stall)
      set_vec[issue_rd] = 1'b1;
    clr_vec = '0;
    if (lsu_gnt && (lsu_rd != 5'd0))
      clr_vec[lsu_rd] = 1'b1;
  end

  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      pending    <= '0;
      starve_cnt <= '0;
      wb_err     <= 1'b0;
    end else begin
      // rd==0 is accepted but leaves the write port untouched.
      RegWrite <= gnt_we;
      if (gnt_we) begin
        write_addr <= gnt_rd;
        write_data <= gnt_data;
      end
      // Clear first and then set, so a load issuing to the same rd keeps its reservation.
      pending <= (pending & ~clr_vec) | set_vec;
      if (lsu_gnt && (lsu_rd != 5'd0) && !pending[lsu_rd])
        wb_err <= 1'b1;
      if (lsu_gnt)
        starve_cnt <= '0;
      else if (lsu_valid && alu_gnt && (starve_cnt != SMAX))
        starve_cnt <= starve_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run,
// compared against a behavioural model of grants, scoreboard and write port.
module tb_wb_arbiter;
  localparam int DW = 32;
  localparam int SM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, lsu_valid, issue_valid, issue_long;
  logic [4:0]    alu_rd, lsu_rd, issue_rd, issue_rs1, issue_rs2;
  logic [DW-1:0] alu_data, lsu_data;
  logic          alu_ready, lsu_ready, stall, RegWrite, wb_err;
  logic [4:0]    write_addr;
  logic [DW-1:0] write_data;

  wb_arbiter #(.DATA_WIDTH(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .stall(stall),
    .RegWrite(RegWrite), .write_addr(write_addr), .write_data(write_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  // reference model state
  bit          m_pend[32];
  int          m_cnt;
  bit          m_err, m_we, m_hold;
  logic [4:0]  m_addr;
  logic [DW-1:0] m_data;
  // DUT handshakes observed in the most recent step
  bit g_alu, g_lsu, g_stall;

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_cnt = 0; m_err = 0; m_we = 0; m_hold = 1; m_addr = '0; m_data = '0;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 0; issue_long = 0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
  endtask

  task automatic set_alu(input bit v, input logic [4:0] rd, input logic [DW-1:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic set_lsu(input bit v, input logic [4:0] rd, input logic [DW-1:0] d);
    lsu_valid = v; lsu_rd = rd; lsu_data = d;
  endtask

  task automatic set_issue(input bit v, input bit lg, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2);
    issue_valid = v; issue_long = lg; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
  endtask

  // One clock: check the combinational handshake, advance the model, check the write port.
  task automatic step(input string tag);
    bit ea, el, es;
    #1;
    ea = alu_valid && !(lsu_valid && m_cnt >= SM);
    el = lsu_valid && !ea;
    es = issue_valid && (m_pend[issue_rs1] || m_pend[issue_rs2] || m_pend[issue_rd]);
    g_alu = alu_ready; g_lsu = lsu_ready; g_stall = stall;
    n_tot++;
    if ({alu_ready, lsu_ready, stall} !== {ea, el, es}) begin
      n_bad++;
      $display("FAIL %s handshake: got alu=%b lsu=%b stall=%b, want alu=%b lsu=%b stall=%b",
               tag, alu_ready, lsu_ready, stall, ea, el, es);
    end
    m_hold = !(ea || el);
    m_we = 0;
    if (ea && alu_rd != 0) begin m_we = 1; m_addr = alu_rd; m_data = alu_data; end
    if (el) begin
      if (lsu_rd != 0) begin
        if (!m_pend[lsu_rd]) m_err = 1;
        m_pend[lsu_rd] = 0;
        m_we = 1; m_addr = lsu_rd; m_data = lsu_data;
      end
      m_cnt = 0;
    end else if (ea && lsu_valid && m_cnt < SM) m_cnt++;
    if (issue_valid && issue_long && issue_rd != 0 && !es) m_pend[issue_rd] = 1;
    @(posedge clk); #1;
    n_tot++;
    if (RegWrite !== m_we || wb_err !== m_err) begin
      n_bad++;
      $display("FAIL %s regwrite/err: got we=%b err=%b, want we=%b err=%b",
               tag, RegWrite, wb_err, m_we, m_err);
    end
    if (m_we || m_hold) begin
      n_tot++;
      if (write_addr !== m_addr || write_data !== m_data) begin
        n_bad++;
        $display("FAIL %s write port: got addr=%0d data=%h, want addr=%0d data=%h",
                 tag, write_addr, write_data, m_addr, m_data);
      end
    end
  endtask

  task automatic do_reset();
    rst = 0; idle();
    @(posedge clk); #1;
    rst = 1; model_reset();
  endtask

  task automatic test_reset();
    rst = 0;
    set_alu(1, 4, 32'h1234); set_lsu(1, 6, 32'h5678); set_issue(1, 1, 2, 3, 4);
    repeat (2) @(posedge clk);
    #1;
    n_tot++;
    if ({alu_ready, lsu_ready, stall, RegWrite, wb_err} !== 5'b0 || write_addr !== 5'd0 || write_data !== '0) begin
      n_bad++;
      $display("FAIL reset: got ar=%b lr=%b st=%b we=%b err=%b addr=%0d data=%h, want all zero",
               alu_ready, lsu_ready, stall, RegWrite, wb_err, write_addr, write_data);
    end
    idle(); rst = 1; model_reset();
  endtask

  task automatic test_alu_only();
    idle();
    set_alu(1, 5, 32'hDEADBEEF);
    step("alu_only");
    n_tot++;
    if (g_alu !== 1'b1 || RegWrite !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL alu_only: got ready=%b we=%b addr=%0d data=%h, want 1 1 5 deadbeef",
               g_alu, RegWrite, write_addr, write_data);
    end
    idle();
    step("alu_idle");
  endtask

  task automatic test_contention();
    idle();
    set_lsu(1, 6, 32'hA0A0A0A0);
    for (int i = 0; i < 5; i++) begin
      bit want_lsu;
      want_lsu = (i == 3);
      set_alu(1, 5'(i + 1), $urandom);
      step("contention");
      n_tot++;
      if (g_lsu !== want_lsu || g_alu !== !want_lsu) begin
        n_bad++;
        $display("FAIL contention cycle %0d: got alu=%b lsu=%b, want alu=%b lsu=%b",
                 i + 1, g_alu, g_lsu, !want_lsu, want_lsu);
      end
      if (g_lsu) set_lsu(1, 6, 32'hB1B1B1B1);
    end
    idle();
    step("contention_idle");
  endtask

  task automatic test_scoreboard();
    bit exp_st[4] = '{1, 1, 1, 0};
    idle();
    set_issue(1, 1, 7, 1, 2);
    step("sb_issue_load");
    set_issue(1, 0, 10, 7, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) set_lsu(1, 7, 32'h77777777);
      if (i == 3) set_lsu(0, 0, 0);
      step("sb_dep");
      n_tot++;
      if (g_stall !== exp_st[i]) begin
        n_bad++;
        $display("FAIL scoreboard cycle %0d: got stall=%b, want %b", i, g_stall, exp_st[i]);
      end
    end
    idle();
  endtask

  task automatic test_same_cycle();
    idle();
    set_lsu(1, 9, 32'h99999999);
    set_issue(1, 1, 9, 0, 0);
    step("same_cycle");
    idle();
    set_issue(1, 0, 11, 9, 0);
    step("same_cycle_chk");
    n_tot++;
    if (g_stall !== 1'b1) begin
      n_bad++;
      $display("FAIL same_cycle: got stall=%b, want 1 (pending[9] kept)", g_stall);
    end
    set_lsu(1, 9, 32'h19191919);
    step("same_cycle_clr");
    set_lsu(0, 0, 0);
    step("same_cycle_free");
    idle();
  endtask

  task automatic test_corner();
    do_reset();
    set_lsu(1, 0, 32'hCAFEF00D);
    step("lsu_rd0");
    n_tot++;
    if (g_lsu !== 1'b1 || RegWrite !== 1'b0 || wb_err !== 1'b0) begin
      n_bad++;
      $display("FAIL lsu_rd0: got ready=%b we=%b err=%b, want 1 0 0", g_lsu, RegWrite, wb_err);
    end
    set_lsu(1, 3, 32'h33333333);
    step("lsu_unreserved");
    n_tot++;
    if (RegWrite !== 1'b1 || write_addr !== 5'd3 || write_data !== 32'h33333333 || wb_err !== 1'b1) begin
      n_bad++;
      $display("FAIL lsu_unreserved: got we=%b addr=%0d data=%h err=%b, want 1 3 33333333 1",
               RegWrite, write_addr, write_data, wb_err);
    end
    idle();
    step("corner_idle");
  endtask

  task automatic test_reset_mid();
    idle();
    set_issue(1, 1, 13, 0, 0);
    step("mid_load");
    idle();
    set_alu(1, 12, 32'h12121212);
    step("mid_accept");
    set_lsu(1, 4, 32'h4);
    set_issue(1, 0, 13, 13, 0);
    rst = 0;
    #1;
    n_tot++;
    if ({alu_ready, lsu_ready, stall, RegWrite, wb_err} !== 5'b0 || write_addr !== 5'd0 || write_data !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got ar=%b lr=%b st=%b we=%b err=%b addr=%0d data=%h, want all zero",
               alu_ready, lsu_ready, stall, RegWrite, wb_err, write_addr, write_data);
    end
    @(posedge clk); #1;
    idle(); rst = 1; model_reset();
    set_issue(1, 0, 13, 13, 0);
    step("post_reset_pend");
    idle();
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 400; i++) begin
      if (!alu_valid || g_alu)
        set_alu(($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom);
      if (!lsu_valid || g_lsu)
        set_lsu(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom);
      if (!issue_valid || !g_stall)
        set_issue(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 40),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step("random");
    end
    idle();
  endtask

  initial begin
    rst = 0;
    idle();
    model_reset();
    g_alu = 0; g_lsu = 0; g_stall = 0;
    test_reset();
    test_alu_only();
    test_contention();
    test_scoreboard();
    test_same_cycle();
    test_corner();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
